inst_loader: RTL and testbench

Writer-side companion to the instruction memory: accepts a big-endian byte stream over a valid/ready handshake, assembles it into 32-bit instruction words and writes them sequentially into instruction RAM starting at byte address 0. It sits between the PS-side program source (GPIO/UART bridge) and the instruction memory write port. It holds the MIPS core in reset until a complete program has been written.

---
 rtl/inst_loader_pkg.sv | 10 +
 rtl/inst_loader.sv | 98 +++++++++
 tb/tb_inst_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared bus widths, enable levels and load FSM states for the instruction loader
package inst_loader_pkg;
    localparam logic ChipEnable = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam int InstAddrBus = 32;
    localparam int InstBus = 32;
    localparam logic [InstBus-1:0] ZeroWord = '0;
    localparam int InstMemNumLog2 = 10;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
endpackage

// File: rtl/inst_loader.sv
// inst_loader: assembles a big-endian byte stream into words written sequentially to instruction RAM
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int MEM_LOG2 = InstMemNumLog2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [MEM_LOG2:0]      i_len,
    input  logic                   i_s_valid,
    input  logic [7:0]             i_s_data,
    output logic                   o_s_ready,
    output logic                   o_we,
    output logic [InstAddrBus-1:0] o_waddr,
    output logic [InstBus-1:0]     o_wdata,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_cpu_hold
);
    localparam logic [MEM_LOG2:0] DEPTH = {1'b1, {MEM_LOG2{1'b0}}};

    state_t r_state, w_next;
    logic [MEM_LOG2:0] r_len, r_widx;
    logic [1:0] r_bcnt;
    logic [23:0] r_sh;
    logic r_we, r_err;
    logic [InstAddrBus-1:0] r_waddr;
    logic [InstBus-1:0] r_wdata;
    logic w_can_start, w_start_ok, w_start_bad, w_last, w_fire, w_word;

    assign w_can_start = i_start && r_state != S_LOAD;
    assign w_start_ok = w_can_start && i_len <= DEPTH;
    assign w_start_bad = w_can_start && i_len > DEPTH;
    // r_widx reaches r_len in the cycle the final write is on the port
    assign w_last = r_widx == r_len;
    assign w_fire = i_s_valid && o_s_ready;
    assign w_word = w_fire && r_bcnt == 2'd3;

    always_comb begin
        w_next = r_state;
        if (w_start_ok)
            w_next = (i_len == '0) ? S_DONE : S_LOAD;
        else if (r_state == S_LOAD && w_last)
            w_next = S_DONE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_len <= '0;
            r_widx <= '0;
            r_bcnt <= '0;
            r_sh <= '0;
        end else if (w_start_ok) begin
            r_len <= i_len;
            r_widx <= '0;
            r_bcnt <= '0;
        end else if (w_fire) begin
            r_bcnt <= r_bcnt + 2'd1;
            r_sh <= {r_sh[15:0], i_s_data};
            if (w_word)
                r_widx <= r_widx + (MEM_LOG2+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_we <= ChipDisable;
            r_waddr <= ZeroWord;
            r_wdata <= ZeroWord;
            r_err <= 1'b0;
        end else begin
            r_we <= w_word ? ChipEnable : ChipDisable;
            r_err <= w_start_bad;
            if (w_word) begin
                r_waddr <= InstAddrBus'({r_widx, 2'b00});
                r_wdata <= {r_sh, i_s_data};
            end
        end
    end

    assign o_s_ready = r_state == S_LOAD && !w_last;
    assign o_we = r_we;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_busy = r_state == S_LOAD;
    assign o_done = r_state == S_DONE;
    assign o_err = r_err;
    assign o_cpu_hold = r_state != S_DONE;
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed scoreboard bench for the instruction loader
module tb_inst_loader;
    localparam int ML = 3;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, s_valid = 1'b0;
    logic [ML:0] len = '0;
    logic [7:0] s_data = '0;
    logic s_ready, we, busy, done, err, cpu_hold;
    logic [31:0] waddr, wdata;

    int checks = 0, errors = 0;
    logic [63:0] q[$];
    logic [1:0] tb_bcnt;
    logic exp_we;

    inst_loader #(.MEM_LOG2(ML)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
        .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(s_ready),
        .o_we(we), .o_waddr(waddr), .o_wdata(wdata), .o_busy(busy),
        .o_done(done), .o_err(err), .o_cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // a write is due exactly one cycle after every 4th accepted byte
    always @(posedge clk) begin
        if (!rst) begin
            tb_bcnt <= 2'd0;
            exp_we <= 1'b0;
        end else begin
            exp_we <= s_valid && s_ready && tb_bcnt == 2'd3;
            if (s_valid && s_ready)
                tb_bcnt <= tb_bcnt + 2'd1;
        end
    end

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (we || exp_we)
                chk("we_timing", {31'd0, we}, {31'd0, exp_we});
            if (we) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: got addr %h data %h expected no write", waddr, wdata);
                end else begin
                    e = q.pop_front();
                    chk("waddr", waddr, e[63:32]);
                    chk("wdata", wdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ML:0] l);
        start = 1'b1;
        len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int gap;
        gap = gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data = b;
        for (int k = 0; k < 50 && !s_ready; k++) tick();
        if (!s_ready) chk("ready_timeout", {31'd0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] a, input int gapmax, input int nbytes, input bit push);
        if (push) q.push_back({a, w});
        for (int k = 0; k < nbytes; k++) send_byte(w[31-8*k -: 8], gapmax);
    endtask

    task automatic chk_flags(input string n, input logic b, input logic d, input logic h, input logic r);
        chk({n, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({n, "_done"}, {31'd0, done}, {31'd0, d});
        chk({n, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
        chk({n, "_ready"}, {31'd0, s_ready}, {31'd0, r});
    endtask

    task automatic chk_reset(input string n);
        chk_flags(n, 1'b0, 1'b0, 1'b1, 1'b0);
        chk({n, "_we"}, {31'd0, we}, 32'd0);
        chk({n, "_err"}, {31'd0, err}, 32'd0);
        chk({n, "_waddr"}, waddr, 32'd0);
        chk({n, "_wdata"}, wdata, 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        chk_reset("reset");
        repeat (3) tick();
        chk_flags("idle", 1'b0, 1'b0, 1'b1, 1'b0);

        do_start(4'd2);
        chk_flags("load2", 1'b1, 1'b0, 1'b1, 1'b1);
        send_word(32'h24020005, 32'h0, 0, 4, 1'b1);
        send_word(32'h3C010010, 32'h4, 0, 4, 1'b1);
        chk_flags("last_we", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("last_we_pulse", {31'd0, we}, 32'd1);
        tick();
        chk_flags("done2", 1'b0, 1'b1, 1'b0, 1'b0);

        do_start(4'd2);
        chk_flags("reload", 1'b1, 1'b0, 1'b1, 1'b1);
        send_word(32'h24020005, 32'h0, 5, 4, 1'b1);
        send_word(32'h3C010010, 32'h4, 5, 4, 1'b1);
        tick();
        chk_flags("done_gaps", 1'b0, 1'b1, 1'b0, 1'b0);

        do_start(4'd9);
        chk("err_in_done", {31'd0, err}, 32'd1);
        chk_flags("err_done", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("err_in_done_clear", {31'd0, err}, 32'd0);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        do_start(4'd0);
        chk_flags("len0", 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        rst = 1'b0;
        tick();
        rst = 1'b1;
        do_start(4'd9);
        chk("err_idle", {31'd0, err}, 32'd1);
        chk_flags("err_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("err_idle_clear", {31'd0, err}, 32'd0);
        chk_flags("still_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        do_start(4'd8);
        chk_flags("load8", 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'(i);
            send_word({8'h10 + v, 8'h20 + v, 8'h30 + v, 8'h40 + v}, 32'(i * 4), 0, 4, 1'b1);
        end
        chk("full_last_addr", waddr, 32'h1C);
        chk_flags("full_last", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_flags("full_done", 1'b0, 1'b1, 1'b0, 1'b0);

        do_start(4'd2);
        send_word(32'hDEADBEEF, 32'h0, 0, 4, 1'b1);
        send_word(32'hCAFEF00D, 32'h4, 0, 2, 1'b0);
        rst = 1'b0;
        tick();
        chk_reset("mid_reset");
        rst = 1'b1;
        repeat (3) tick();
        chk_flags("post_reset", 1'b0, 1'b0, 1'b1, 1'b0);
        do_start(4'd1);
        send_word(32'h8C220004, 32'h0, 0, 4, 1'b1);
        tick();
        chk_flags("reload_done", 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
